port_uart_tx: RTL and testbench

PORT_UART_TX -- requirements
Module: port_uart_tx

---
 rtl/port_io_pkg.sv | 14 +
 rtl/port_uart_tx_if.sv | 11 +
 rtl/port_fifo.sv | 55 +++++
 rtl/port_uart_tx.sv | 160 ++++++++++++++++
 tb/tb_port_uart_tx.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/port_io_pkg.sv
// Shared types and framing constants for the port-mapped UART sink.
package port_io_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int FRAME_BITS     = 10;
   localparam int BYTES_PER_WORD = 2;

endpackage

// File: rtl/port_uart_tx_if.sv
// CPU port-write bus: strobe, target port number and data word.
interface port_uart_tx_if;

   logic        write_out;
   logic [15:0] out_port;
   logic [15:0] out_data;

   modport master (output write_out, out_port, out_data);
   modport slave  (input  write_out, out_port, out_data);

endinterface

// File: rtl/port_fifo.sv
// Word FIFO with occupancy count; a push while full is only taken
// when a pop happens in the same cycle.
module port_fifo #(
   parameter int  WIDTH = 16,
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    head;
   logic [AW-1:0]    tail;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign dout    = mem[head];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Storage array; contents are don't-care while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[tail] <= din;
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) tail <= tail + 1'b1;
         if (do_pop)  head <= head + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/port_uart_tx.sv
// Port-mapped UART sink: matching CPU port writes are queued and each
// 16-bit word is sent as two 8N1 frames, low byte first.
//
//   state | meaning
//   IDLE  | line high, waiting for a queued word
//   START | start bit (0) for the current byte
//   DATA  | data bits, LSB first, indexed by bit_idx
//   STOP  | stop bit (1); then high byte, next word, or idle
module port_uart_tx #(
   parameter logic [15:0] PORT  = 16'h0001,
   parameter int          DIV   = 868,
   parameter int          DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   port_uart_tx_if.slave  bus,
   output logic           tx,
   output logic           busy,
   output logic           full,
   output logic           overflow
);
   import port_io_pkg::*;

   localparam int          CW     = $clog2(DEPTH) + 1;
   localparam logic [15:0] RELOAD = 16'(DIV - 1);

   tx_state_t   state, state_nxt;
   logic [15:0] bit_cnt, bit_cnt_nxt;
   logic [2:0]  bit_idx, bit_idx_nxt, idx_inc;
   logic        byte_sel, byte_sel_nxt;
   logic [15:0] word_q, word_nxt;
   logic        tx_nxt;
   logic [7:0]  cur_byte;
   logic        pop;
   logic        push;
   logic        port_hit;
   logic        fifo_empty;
   logic [15:0] head_word;
   logic [CW-1:0] fifo_count;

   assign port_hit = bus.write_out && (bus.out_port == PORT);
   assign push     = port_hit && !rst;
   assign busy     = (state != IDLE) || (fifo_count != '0);
   assign cur_byte = byte_sel ? word_q[15:8] : word_q[7:0];
   assign idx_inc  = bit_idx + 3'd1;

   port_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (bus.out_data),
      .dout  (head_word),
      .full  (full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Next-state, bit timing and line value; tx is computed one step ahead
   // so the registered line changes on the same edge as the state.
   always_comb begin
      state_nxt    = state;
      bit_cnt_nxt  = bit_cnt;
      bit_idx_nxt  = bit_idx;
      byte_sel_nxt = byte_sel;
      word_nxt     = word_q;
      tx_nxt       = tx;
      pop          = 1'b0;
      case (state)
         IDLE: begin
            tx_nxt = 1'b1;
            if (!fifo_empty) begin
               pop          = 1'b1;
               word_nxt     = head_word;
               byte_sel_nxt = 1'b0;
               bit_cnt_nxt  = RELOAD;
               state_nxt    = START;
               tx_nxt       = 1'b0;
            end
         end
         START: begin
            if (bit_cnt == '0) begin
               bit_cnt_nxt = RELOAD;
               bit_idx_nxt = 3'd0;
               state_nxt   = DATA;
               tx_nxt      = cur_byte[0];
            end else begin
               bit_cnt_nxt = bit_cnt - 16'd1;
            end
         end
         DATA: begin
            if (bit_cnt == '0) begin
               bit_cnt_nxt = RELOAD;
               if (bit_idx == 3'd7) begin
                  state_nxt = STOP;
                  tx_nxt    = 1'b1;
               end else begin
                  bit_idx_nxt = idx_inc;
                  tx_nxt      = cur_byte[idx_inc];
               end
            end else begin
               bit_cnt_nxt = bit_cnt - 16'd1;
            end
         end
         STOP: begin
            if (bit_cnt == '0) begin
               bit_cnt_nxt = RELOAD;
               bit_idx_nxt = 3'd0;
               if (!byte_sel) begin
                  byte_sel_nxt = 1'b1;
                  state_nxt    = START;
                  tx_nxt       = 1'b0;
               end else if (!fifo_empty) begin
                  pop          = 1'b1;
                  word_nxt     = head_word;
                  byte_sel_nxt = 1'b0;
                  state_nxt    = START;
                  tx_nxt       = 1'b0;
               end else begin
                  bit_cnt_nxt = '0;
                  state_nxt   = IDLE;
                  tx_nxt      = 1'b1;
               end
            end else begin
               bit_cnt_nxt = bit_cnt - 16'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
         end
      endcase
   end

   // FSM, counters and line register; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         byte_sel <= 1'b0;
         word_q   <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_nxt;
         bit_cnt  <= bit_cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         byte_sel <= byte_sel_nxt;
         word_q   <= word_nxt;
         tx       <= tx_nxt;
      end
   end

   // Sticky drop flag: a matching write arrived with no room and no pop.
   always_ff @(posedge clk) begin
      if (rst)                              overflow <= 1'b0;
      else if (port_hit && full && !pop)    overflow <= 1'b1;
   end

endmodule

// File: tb/tb_port_uart_tx.sv
// Directed bench for port_uart_tx with PORT=1, DIV=4, DEPTH=4.
module tb_port_uart_tx;
   import port_io_pkg::*;

   localparam int DIV      = 4;
   localparam int DEPTH    = 4;
   localparam int BYTE_CYC = FRAME_BITS * DIV;
   localparam int WORD_CYC = FRAME_BITS * BYTES_PER_WORD * DIV;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx, busy, full, overflow;

   port_uart_tx_if bus_if ();

   port_uart_tx #(.PORT(16'h0001), .DIV(DIV), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus_if),
      .tx       (tx),
      .busy     (busy),
      .full     (full),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] rx_bytes [32];
   int         rx_start [32];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Waits for a start bit, then samples each bit in its middle.
   task automatic rx_frame(output logic [7:0] b, output int st);
      bit found;
      found = 1'b0;
      b     = '0;
      st    = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (tx === 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      check_val("rx_start_seen", 32'(found), 32'd1);
      if (!found) return;
      st = cyc;
      repeat (DIV/2) @(negedge clk);
      check_val("start_bit", 32'(tx), 32'd0);
      for (int k = 0; k < 8; k++) begin
         repeat (DIV) @(negedge clk);
         b[k] = tx;
      end
      repeat (DIV) @(negedge clk);
      check_val("stop_bit", 32'(tx), 32'd1);
   endtask

   task automatic rx_frames(input int n);
      logic [7:0] b;
      int         st;
      for (int i = 0; i < n; i++) begin
         rx_frame(b, st);
         rx_bytes[i] = b;
         rx_start[i] = st;
      end
   endtask

   task automatic wr(input logic [15:0] port, input logic [15:0] data);
      bus_if.write_out = 1'b1;
      bus_if.out_port  = port;
      bus_if.out_data  = data;
      @(negedge clk);
      bus_if.write_out = 1'b0;
   endtask

   task automatic wait_idle(input string tag, output int at);
      bit found;
      found = 1'b0;
      at    = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            found = 1'b1;
            at    = cyc;
            break;
         end
      end
      check_val(tag, 32'(found), 32'd1);
   endtask

   initial begin
      int w, t_end, p1;
      bit saw_low, saw_busy;
      logic [15:0] t5_words [3];
      logic [15:0] t6_words [5];
      logic [7:0]  t6_exp   [12];

      bus_if.write_out = 1'b0;
      bus_if.out_port  = '0;
      bus_if.out_data  = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check_val("rst_tx", 32'(tx), 32'd1);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_full", 32'(full), 32'd0);
      check_val("rst_overflow", 32'(overflow), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single word A55A: frames 5A then A5, 80 cycles, write latency
      wr(16'h0001, 16'hA55A);
      w = cyc;
      check_val("t1_busy_after_push", 32'(busy), 32'd1);
      check_val("t1_tx_high_at_push", 32'(tx), 32'd1);
      rx_frames(2);
      check_val("t1_byte0", 32'(rx_bytes[0]), 32'h5A);
      check_val("t1_byte1", 32'(rx_bytes[1]), 32'hA5);
      check_val("t1_latency", 32'(rx_start[0]), 32'(w + 1));
      check_val("t1_byte1_start", 32'(rx_start[1]), 32'(rx_start[0] + BYTE_CYC));
      wait_idle("t1_idle", t_end);
      check_val("t1_word_cycles", 32'(t_end), 32'(rx_start[0] + WORD_CYC));
      check_val("t1_tx_idle", 32'(tx), 32'd1);

      // Non-matching port is ignored
      wr(16'h0002, 16'h1234);
      saw_low  = 1'b0;
      saw_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (tx !== 1'b1) saw_low = 1'b1;
         if (busy !== 1'b0) saw_busy = 1'b1;
         @(negedge clk);
      end
      check_val("t2_tx_low_seen", 32'(saw_low), 32'd0);
      check_val("t2_busy_seen", 32'(saw_busy), 32'd0);
      check_val("t2_count", 32'(dut.u_fifo.count), 32'd0);

      // Seven back-to-back writes: 1..5 sent, 6 and 7 dropped
      fork
         rx_frames(10);
         begin
            for (int i = 1; i <= 7; i++) begin
               bus_if.write_out = 1'b1;
               bus_if.out_port  = 16'h0001;
               bus_if.out_data  = 16'(i);
               @(negedge clk);
               check_val($sformatf("t3_full_w%0d", i), 32'(full), 32'(i >= 5));
               check_val($sformatf("t3_ovf_w%0d", i), 32'(overflow), 32'(i >= 6));
            end
            bus_if.write_out = 1'b0;
         end
      join
      for (int i = 0; i < 5; i++) begin
         check_val($sformatf("t3_lo%0d", i + 1), 32'(rx_bytes[2*i]), 32'(i + 1));
         check_val($sformatf("t3_hi%0d", i + 1), 32'(rx_bytes[2*i+1]), 32'd0);
      end
      wait_idle("t3_idle", t_end);
      check_val("t3_overflow_sticky", 32'(overflow), 32'd1);

      // Two words one cycle apart: no idle gap between them
      fork
         rx_frames(4);
         begin
            wr(16'h0001, 16'hC33C);
            @(negedge clk);
            wr(16'h0001, 16'h0FF0);
         end
      join
      check_val("t4_b0", 32'(rx_bytes[0]), 32'h3C);
      check_val("t4_b1", 32'(rx_bytes[1]), 32'hC3);
      check_val("t4_b2", 32'(rx_bytes[2]), 32'hF0);
      check_val("t4_b3", 32'(rx_bytes[3]), 32'h0F);
      check_val("t4_no_gap", 32'(rx_start[2]), 32'(rx_start[0] + WORD_CYC));
      wait_idle("t4_idle", t_end);

      // Reset during data bit 3 of the first byte of a 3-word burst
      t5_words = '{16'h12F7, 16'h3456, 16'h789A};
      p1 = 0;
      for (int i = 0; i < 3; i++) begin
         bus_if.write_out = 1'b1;
         bus_if.out_port  = 16'h0001;
         bus_if.out_data  = t5_words[i];
         @(negedge clk);
         if (i == 0) p1 = cyc;
      end
      bus_if.write_out = 1'b0;
      while (cyc < p1 + 18) @(negedge clk);
      check_val("t5_bit3_before_rst", 32'(tx), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("t5_tx", 32'(tx), 32'd1);
      check_val("t5_busy", 32'(busy), 32'd0);
      check_val("t5_full", 32'(full), 32'd0);
      check_val("t5_overflow", 32'(overflow), 32'd0);
      saw_low  = 1'b0;
      saw_busy = 1'b0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) saw_low = 1'b1;
         if (busy !== 1'b0) saw_busy = 1'b1;
      end
      check_val("t5_no_frames", 32'(saw_low), 32'd0);
      check_val("t5_stays_idle", 32'(saw_busy), 32'd0);

      // Write while full in the same cycle as an internal pop
      t6_words = '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A};
      t6_exp   = '{8'h02, 8'h01, 8'h04, 8'h03, 8'h06, 8'h05,
                   8'h08, 8'h07, 8'h0A, 8'h09, 8'h00, 8'hFF};
      fork
         rx_frames(12);
         begin
            p1 = 0;
            for (int i = 0; i < 5; i++) begin
               bus_if.write_out = 1'b1;
               bus_if.out_port  = 16'h0001;
               bus_if.out_data  = t6_words[i];
               @(negedge clk);
               if (i == 0) p1 = cyc;
            end
            bus_if.write_out = 1'b0;
            check_val("t6_full_after_fill", 32'(full), 32'd1);
            while (cyc < p1 + 80) @(negedge clk);
            check_val("t6_full_before_pop", 32'(full), 32'd1);
            wr(16'h0001, 16'hFF00);
            check_val("t6_count", 32'(dut.u_fifo.count), 32'd4);
            check_val("t6_full_after", 32'(full), 32'd1);
            check_val("t6_no_overflow", 32'(overflow), 32'd0);
         end
      join
      for (int i = 0; i < 12; i++)
         check_val($sformatf("t6_byte%0d", i), 32'(rx_bytes[i]), 32'(t6_exp[i]));
      wait_idle("t6_idle", t_end);
      check_val("t6_tx_idle", 32'(tx), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
